// File: rtl/fpmul_initiator.sv
// Stimulus initiator for the FP multiplier harness: issues LFSR operand pairs,
// collects products and re-aligns each with its operands using the fixed lag.
module fpmul_initiator #(
  parameter int          NUM_TXN    = 16,
  parameter int          PIPE_DEPTH = 2,
  parameter logic [31:0] SEED_A     = 32'h3F80_0001,
  parameter logic [31:0] SEED_B     = 32'h4000_0003
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        in_valid,
  input  logic        in_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  input  logic        out_valid,
  output logic        out_ready,
  input  logic [31:0] out_data,
  output logic        res_valid,
  output logic [31:0] res_a,
  output logic [31:0] res_b,
  output logic [31:0] res_z,
  output logic        busy,
  output logic        done
);

  localparam int              TOTAL      = NUM_TXN + PIPE_DEPTH;
  localparam int              CNT_W      = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] NUM_C     = CNT_W'(NUM_TXN);
  localparam logic [CNT_W-1:0] PIPE_C    = CNT_W'(PIPE_DEPTH);
  localparam logic [31:0]     LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0]     SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0]     SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;

  function automatic logic [31:0] lfsrNext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  state_e           state_q;
  logic [31:0]      lfsr_a_q, lfsr_b_q;
  logic [31:0]      lfsr_a_d, lfsr_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hist_a_q [PIPE_DEPTH+1];
  logic [31:0]      hist_b_q [PIPE_DEPTH+1];
  logic             in_valid_q, out_ready_q, res_valid_q, busy_q, done_q;
  logic [31:0]      a_q, b_q, res_a_q, res_b_q, res_z_q;

  assign lfsr_a_d = lfsrNext(lfsr_a_q);
  assign lfsr_b_d = lfsrNext(lfsr_b_q);
  assign cnt_d    = cnt_q + 1'b1;

  // hist_*_q[0] is the pair just sent; hist_*_q[PIPE_DEPTH] is the pair whose
  // product arrives on the output handshake that follows it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      lfsr_a_q    <= SEED_A_EFF;
      lfsr_b_q    <= SEED_B_EFF;
      cnt_q       <= '0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      res_a_q     <= 32'h0;
      res_b_q     <= 32'h0;
      res_z_q     <= 32'h0;
      for (int i = 0; i <= PIPE_DEPTH; i++) begin
        hist_a_q[i] <= 32'h0;
        hist_b_q[i] <= 32'h0;
      end
    end else begin
      res_valid_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q    <= SEND;
            lfsr_a_q   <= SEED_A_EFF;
            lfsr_b_q   <= SEED_B_EFF;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            in_valid_q <= 1'b1;
            a_q        <= SEED_A_EFF;
            b_q        <= SEED_B_EFF;
            for (int i = 0; i <= PIPE_DEPTH; i++) begin
              hist_a_q[i] <= 32'h0;
              hist_b_q[i] <= 32'h0;
            end
          end
        end
        SEND: begin
          if (in_valid_q && in_ready) begin
            hist_a_q[0] <= a_q;
            hist_b_q[0] <= b_q;
            for (int i = 1; i <= PIPE_DEPTH; i++) begin
              hist_a_q[i] <= hist_a_q[i-1];
              hist_b_q[i] <= hist_b_q[i-1];
            end
            lfsr_a_q    <= lfsr_a_d;
            lfsr_b_q    <= lfsr_b_d;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b1;
            state_q     <= RECV;
          end
        end
        RECV: begin
          if (out_ready_q && out_valid) begin
            out_ready_q <= 1'b0;
            cnt_q       <= cnt_d;
            if (cnt_q >= PIPE_C) begin
              res_valid_q <= 1'b1;
              res_a_q     <= hist_a_q[PIPE_DEPTH];
              res_b_q     <= hist_b_q[PIPE_DEPTH];
              res_z_q     <= out_data;
            end
            if (cnt_d == TOTAL_C) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= SEND;
              in_valid_q <= 1'b1;
              // Past the real transactions, zero pairs drain the multiplier.
              a_q        <= (cnt_d < NUM_C) ? lfsr_a_q : 32'h0;
              b_q        <= (cnt_d < NUM_C) ? lfsr_b_q : 32'h0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_valid  = in_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign out_ready = out_ready_q;
  assign res_valid = res_valid_q;
  assign res_a     = res_a_q;
  assign res_b     = res_b_q;
  assign res_z     = res_z_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fpmul_initiator.sv
// Self-checking bench for fpmul_initiator: a lagged multiplier responder plus a
// scoreboard of expected (a, b, z) triples filled as operand pairs are accepted.
module tb_fpmul_initiator;

  localparam int          NUM  = 4;
  localparam int          PIPE = 2;
  localparam logic [31:0] SA   = 32'h3F80_0001;
  localparam logic [31:0] SB   = 32'h4000_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_ready = 1'b0;
  logic        out_valid = 1'b0;
  logic [31:0] out_data = 32'h0;
  logic        in_valid, out_ready, res_valid, busy, done;
  logic [31:0] A, B, res_a, res_b, res_z;

  fpmul_initiator #(
    .NUM_TXN(NUM), .PIPE_DEPTH(PIPE), .SEED_A(SA), .SEED_B(SB)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .res_valid(res_valid), .res_a(res_a), .res_b(res_b), .res_z(res_z),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] modelA, modelB, firstA, firstB;
  logic [31:0] prodQ [$];
  logic [95:0] sbQ [$];
  int txnIdx, outIdx, resCount, inHsCount, prevK;
  int inStallTxn = -1, inStallLeft = 0;
  int outStallTxn = -1, outStallLeft = 0;
  int startRecvTxn = -1;
  bit startNext = 0, prevStart = 0, prevInHs = 0, prevOutHs = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [31:0] mulModel(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  task automatic newRun();
    modelA = SA; modelB = SB;
    txnIdx = 0; outIdx = 0; resCount = 0; inHsCount = 0;
    firstA = 32'h0; firstB = 32'h0;
    prodQ.delete(); sbQ.delete();
    for (int i = 0; i < PIPE; i++) prodQ.push_back(32'hBAD0_0000 + 32'(i));
    startNext = 1;
  endtask

  // One clock of the responder: observe outputs, then drive inputs at negedge.
  task automatic applyStimulus();
    logic [31:0] expA, expB, p;
    logic [95:0] e;
    @(negedge clk);
    if (prevStart) begin
      checkOutput("startInValid", 32'(in_valid), 32'd1);
      checkOutput("startBusy", 32'(busy), 32'd1);
      checkOutput("startDone", 32'(done), 32'd0);
    end
    if (prevInHs) begin
      checkOutput("hsInValidLow", 32'(in_valid), 32'd0);
      checkOutput("hsOutReady", 32'(out_ready), 32'd1);
    end
    if (prevOutHs) begin
      if (prevK == NUM + PIPE - 1) begin
        checkOutput("endDone", 32'(done), 32'd1);
        checkOutput("endBusy", 32'(busy), 32'd0);
        checkOutput("endInValid", 32'(in_valid), 32'd0);
      end else begin
        checkOutput("nextInValid", 32'(in_valid), 32'd1);
      end
    end
    checkOutput("resValid", 32'(res_valid), 32'(prevOutHs && prevK >= PIPE));
    checkOutput("excl", 32'(in_valid & out_ready), 32'd0);
    if (res_valid) begin
      resCount++;
      if (sbQ.size() == 0) checkOutput("resExtra", 32'd1, 32'd0);
      else begin
        e = sbQ.pop_front();
        checkOutput("resA", res_a, e[95:64]);
        checkOutput("resB", res_b, e[63:32]);
        checkOutput("resZ", res_z, e[31:0]);
      end
    end
    prevStart = startNext; prevInHs = 0; prevOutHs = 0;
    start = startNext; startNext = 0;
    in_ready = 1'b0;
    if (in_valid) begin
      expA = (txnIdx < NUM) ? modelA : 32'h0;
      expB = (txnIdx < NUM) ? modelB : 32'h0;
      if (txnIdx == inStallTxn && inStallLeft > 0) begin
        inStallLeft--;
        checkOutput("stallA", A, expA);
        checkOutput("stallB", B, expB);
      end else begin
        in_ready = 1'b1;
        checkOutput("opA", A, expA);
        checkOutput("opB", B, expB);
        if (txnIdx == 0) begin firstA = A; firstB = B; end
        p = mulModel(expA, expB);
        prodQ.push_back(p);
        if (txnIdx < NUM) sbQ.push_back({expA, expB, p});
        modelA = lfsrStep(modelA); modelB = lfsrStep(modelB);
        txnIdx++; inHsCount++; prevInHs = 1;
      end
    end
    out_valid = 1'b0;
    if (out_ready) begin
      if (startRecvTxn >= 0 && outIdx == startRecvTxn) begin
        start = 1'b1;
        startRecvTxn = -1;
      end
      if (outIdx == outStallTxn && outStallLeft > 0) outStallLeft--;
      else begin
        out_valid = 1'b1;
        out_data = (prodQ.size() > 0) ? prodQ.pop_front() : 32'hDEAD_BEEF;
        prevK = outIdx; outIdx++; prevOutHs = 1;
      end
    end
  endtask

  task automatic runUntilDone(input int maxCycles);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!(prevOutHs && prevK == NUM + PIPE - 1) && n < maxCycles);
    if (n >= maxCycles) checkOutput("timeoutDone", 32'd0, 32'd1);
    applyStimulus();
    checkOutput("inHsCount", 32'(inHsCount), 32'(NUM + PIPE));
    checkOutput("resCount", 32'(resCount), 32'(NUM));
    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, 32'({in_valid, out_ready, res_valid, busy, done}), 32'd0);
    checkOutput({tag, "AB"}, A | B, 32'h0);
    checkOutput({tag, "Res"}, res_a | res_b | res_z, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      checkAllZero("idle");
    end

    newRun();
    runUntilDone(200);
    checkOutput("firstA", firstA, 32'h3F80_0001);
    checkOutput("firstB", firstB, 32'h4000_0003);

    newRun();
    inStallTxn = 1; inStallLeft = 10;
    outStallTxn = 3; outStallLeft = 7;
    runUntilDone(300);
    checkOutput("inStallUsed", 32'(inStallLeft), 32'd0);
    checkOutput("outStallUsed", 32'(outStallLeft), 32'd0);

    newRun();
    startRecvTxn = 2;
    runUntilDone(200);
    checkOutput("recvStartUsed", 32'(startRecvTxn), 32'hFFFF_FFFF);

    newRun();
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (resCount < 2 && n < 200);
    if (n >= 200) checkOutput("timeoutRes", 32'd0, 32'd1);
    rst = 1'b0; start = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
    #1;
    checkAllZero("midReset");
    prevStart = 0; prevInHs = 0; prevOutHs = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus();
    newRun();
    runUntilDone(200);
    checkOutput("rerunFirstA", firstA, 32'h3F80_0001);
    checkOutput("rerunFirstB", firstB, 32'h4000_0003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpmul_initiator.md
# fpmul_initiator

Hardware stimulus initiator for the floating-point multiplier harness. It sits on the far side of the multiplier wrapper's valid/ready interfaces. It generates pseudo-random IEEE-754 single-precision operand pairs from two LFSRs and offers them on the input channel. It then accepts each product on the output channel and re-aligns every product with the operand pair that produced it, using the multiplier's fixed transaction lag. Aligned (a, b, z) triples go out on a result strobe to a downstream checker or logger.

## Interface
Parameters:
- NUM_TXN, 16: number of real operand pairs per run (≥1).
- PIPE_DEPTH, 2: transaction lag between an operand pair and its product (≥1).
- SEED_A, 32'h3F80_0001: LFSR seed for operand A; a zero seed is replaced by 32'h1.
- SEED_B, 32'h4000_0003: LFSR seed for operand B; a zero seed is replaced by 32'h1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- in_valid  out  1  operand pair offered.
- in_ready  in  1  multiplier accepts the operand pair.
- A  out  32  operand A.
- B  out  32  operand B.
- out_valid  in  1  multiplier presents a product.
- out_ready  out  1  initiator accepts the product.
- out_data  in  32  product.
- res_valid  out  1  one-cycle strobe: aligned triple valid.
- res_a  out  32  operand A of the aligned triple.
- res_b  out  32  operand B of the aligned triple.
- res_z  out  32  product of the aligned triple.
- busy  out  1  run in progress (SEND or RECV).
- done  out  1  run complete; held until the next start or reset.

## Operation
- States: IDLE, SEND, RECV, DONE.
  - IDLE/DONE, start=1: go to SEND. Load both LFSRs with their seeds, clear txn_cnt, clear the history, clear done.
  - SEND: in_valid=1. A/B hold the current LFSR values, or 0 during flush. On in_valid&&in_ready, push (A,B) into the history, advance both LFSRs, and go to RECV.
  - RECV: out_ready=1. On out_valid&&out_ready, capture out_data, increment txn_cnt, and go to SEND. If txn_cnt reaches NUM_TXN+PIPE_DEPTH, go to DONE instead.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003, shift right. Advances only on an accepted input handshake. The first operand of a run equals its seed.
- Flush: transaction indices NUM_TXN .. NUM_TXN+PIPE_DEPTH-1 send A=B=32'h0. These transactions drain the products still held in the multiplier.
- History: shift register of PIPE_DEPTH+1 operand pairs.
  - The product captured at transaction index k belongs to the pair sent at index k-PIPE_DEPTH.
  - For k<PIPE_DEPTH the product is discarded and res_valid stays 0.
  - Total res_valid pulses per run: exactly NUM_TXN.
- Operands and products are opaque 32-bit words; the block does no arithmetic.
- start while busy is ignored.
- in_valid and out_ready are never 1 in the same cycle.

## Timing
- Reset (rst=0, async): state=IDLE, in_valid=0, A=B=0, out_ready=0, res_valid=0, res_a=res_b=res_z=0, busy=0, done=0. The history and txn_cnt clear, and the LFSRs load their seeds.
- start sampled at edge t: in_valid=1 and busy=1 from t+1.
- Input handshake at edge t: in_valid=0 and out_ready=1 from t+1. A/B keep their values; the LFSR value is already updated.
- in_ready low: in_valid stays 1 and A/B stay stable indefinitely. There is no timeout.
- Output handshake at edge t: out_ready=0 from t+1.
  - For k≥PIPE_DEPTH: res_valid=1 for exactly the cycle t+1, with res_z=out_data sampled at t. res_a/res_b/res_z hold until the next strobe.
  - Also at t+1: in_valid=1 (next pair), or done=1 with busy=0.
- Minimum transaction period: 2 cycles. Minimum run length: 2·(NUM_TXN+PIPE_DEPTH)+1 cycles after start.
- A reset mid-run aborts immediately. No partial result is emitted afterwards. The next run repeats the identical operand sequence.

## Test plan
- Reset/idle: hold rst=0 for 3 cycles, then run 10 cycles with start=0 → every output stays 0 and in_valid never rises.
- Basic run, NUM_TXN=4, PIPE_DEPTH=2, responder always ready, product returned with a 2-transaction lag:
  - Exactly 6 input handshakes; the first has A=32'h3F80_0001, B=32'h4000_0003 and the last two have A=B=0.
  - 4 res_valid pulses, each with res_z equal to the responder's product of res_a×res_b.
  - done=1 and busy=0 after the 6th output handshake.
- Input backpressure: in_ready=0 for 10 cycles while in_valid=1 → A/B stable, in_valid stays 1, no LFSR advance. Proceeds one cycle after in_ready=1.
- Output stall: out_valid delayed 7 cycles → out_ready stays 1, res_valid stays 0, in_valid stays 0 until the handshake.
- Mid-run reset after the 2nd res_valid pulse → all outputs are 0 within the same cycle. A new start reissues A=32'h3F80_0001 first.
- Start handling: start pulsed during RECV → ignored and the run count is unchanged. start in DONE → done=0 and in_valid=1 on the next cycle.
